// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that locks one requester onto a shared FIFO write port
// for a whole burst, releasing on the last beat or after MAX_BEATS beats.
module rr_burst_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256,
  localparam int IDX_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH+IDX_W:0]     fifo_data,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic [CNT_W-1:0]              beat_cnt,
  output logic                          burst_err
);

  // Handshake: a beat moves in a cycle where the granted requester holds
  // req_valid high and sees req_ready high; fifo_wr_en marks exactly those cycles.
  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W:0]        cand;
  logic                  any_valid;
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept, force_rel, burst_end;

  // Scan upward from rr_ptr+1; the wrap is a compare-and-subtract so that
  // non-power-of-two NUM_REQ never lands on a nonexistent requester.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NUM_REQ)) cand = cand - (IDX_W + 1)'(NUM_REQ);
      if (!any_valid && req_valid[cand[IDX_W-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[IDX_W-1:0];
      end
    end
  end

  assign g_valid   = req_valid[grant_idx];
  assign g_last    = req_last[grant_idx];
  assign g_data    = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state == BURST) && g_valid && !fifo_full;
  assign force_rel = accept && !g_last && (beat_cnt == CNT_W'(MAX_BEATS - 1));
  assign burst_end = accept && (g_last || force_rel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx <= '0;
      beat_cnt  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      burst_err <= 1'b0;
    end else begin
      burst_err <= force_rel;
      if (state == IDLE && any_valid) grant_idx <= winner;
      if (burst_end) begin
        beat_cnt <= '0;
        rr_ptr   <= grant_idx;
      end else if (accept) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

  // Only the granted slice reaches fifo_data, so other requesters' payloads
  // cannot leak into the entry.
  always_comb begin
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    fifo_data   = '0;
    grant_valid = (state == BURST);
    if (state == BURST) begin
      req_ready[grant_idx] = !fifo_full;
      fifo_wr_en           = accept;
      fifo_data            = {g_last, grant_idx, g_data};
    end
  end

endmodule
